// File: rtl/eth_10g_st_rl_timing_adapter.sv
// Avalon-ST ready-latency timing adapter for the 10G MAC datapath.
// It converts an upstream ready latency L to a downstream ready latency M through a
// show-ahead FIFO. Upstream grants are credit based, so a beat that honours latency L
// always finds space. Upstream protocol violations and FIFO overflow are reported
// on sticky error flags.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   in_ready      grant to upstream (combinational from registers and reset)
//   in_valid      upstream beat valid
//   in_data       upstream payload
//   out_ready     downstream ready
//   out_valid     beat valid toward downstream (combinational from registers)
//   out_data      FIFO head payload (show-ahead)
//   err_protocol  sticky: in_valid seen without a grant L cycles earlier
//   err_overflow  sticky: beat arrived while full with no pop; the beat is dropped
//   fill_level    current FIFO occupancy
module eth_10g_st_rl_timing_adapter #(
  parameter int unsigned DATA_WIDTH        = 72,
  parameter int unsigned IN_READY_LATENCY  = 0,
  parameter int unsigned OUT_READY_LATENCY = 0,
  parameter int unsigned DEPTH             = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      in_ready,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      err_protocol,
  output logic                      err_overflow,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Wide enough for count plus up to four outstanding grants.
  localparam int unsigned SW = CW + 3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         grants;
  logic                  accept;
  logic                  proto_err;
  logic                  pop;
  logic                  full;
  logic                  wr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Upstream side: grant history and accept qualification.
  generate
    if (IN_READY_LATENCY == 0) begin : g_in_l0
      assign grants    = '0;
      assign accept    = in_valid & in_ready;
      assign proto_err = 1'b0;
    end else begin : g_in_hist
      localparam int unsigned L = IN_READY_LATENCY;
      // Bit i holds in_ready from i+1 cycles ago.
      logic [L-1:0] ready_hist;

      always_ff @(posedge clk) begin
        if (reset) ready_hist <= '0;
        else       ready_hist <= L'({ready_hist, in_ready});
      end

      // Grants still inside their accept window count against free space.
      always_comb begin
        grants = '0;
        for (int unsigned i = 0; i < L; i++) grants = grants + SW'(ready_hist[i]);
      end

      assign accept    = in_valid;
      assign proto_err = in_valid & ~ready_hist[L-1];
    end
  endgenerate

  assign in_ready = ~reset & ((SW'(count) + grants) < SW'(DEPTH));

  // Downstream side: present the head when the delayed out_ready allows it.
  generate
    if (OUT_READY_LATENCY == 0) begin : g_out_l0
      assign out_valid = (count != '0);
      assign pop       = out_valid & out_ready;
    end else begin : g_out_hist
      localparam int unsigned M = OUT_READY_LATENCY;
      logic [M-1:0] ready_hist;

      always_ff @(posedge clk) begin
        if (reset) ready_hist <= '0;
        else       ready_hist <= M'({ready_hist, out_ready});
      end

      assign out_valid = (count != '0) & ready_hist[M-1];
      assign pop       = out_valid;
    end
  endgenerate

  assign full       = (count == CW'(DEPTH));
  // A full FIFO can still take a beat if the head leaves in the same cycle.
  assign wr         = accept & (~full | pop);
  assign out_data   = mem[rptr];
  assign fill_level = count;

  // Pointers, occupancy and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      err_protocol <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= ptr_inc(wptr);
      if (pop) rptr <= ptr_inc(rptr);
      count <= count + CW'(wr) - CW'(pop);
      if (proto_err)              err_protocol <= 1'b1;
      if (accept & full & ~pop)   err_overflow <= 1'b1;
    end
  end

  // Payload storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr & ~reset) mem[wptr] <= in_data;
  end

endmodule

// File: tb/tb_eth_10g_st_rl_timing_adapter.sv
module tb_eth_10g_st_rl_timing_adapter;

  localparam int unsigned DW = 72;
  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, iv, ordy, ir, ov, ep, eo;
  logic [DW-1:0] id [NI];
  logic [DW-1:0] od [NI];
  logic [3:0]    fl [NI];

  // Instance k: upstream latency li[k], downstream latency lo[k], depth 8.
  int li [NI] = '{0, 2, 1};
  int lo [NI] = '{0, 0, 3};

  eth_10g_st_rl_timing_adapter #(.DATA_WIDTH(DW), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(0), .DEPTH(8)) u_l0m0 (
    .clk(clk), .reset(rst[0]), .in_ready(ir[0]), .in_valid(iv[0]), .in_data(id[0]),
    .out_ready(ordy[0]), .out_valid(ov[0]), .out_data(od[0]),
    .err_protocol(ep[0]), .err_overflow(eo[0]), .fill_level(fl[0]));

  eth_10g_st_rl_timing_adapter #(.DATA_WIDTH(DW), .IN_READY_LATENCY(2), .OUT_READY_LATENCY(0), .DEPTH(8)) u_l2m0 (
    .clk(clk), .reset(rst[1]), .in_ready(ir[1]), .in_valid(iv[1]), .in_data(id[1]),
    .out_ready(ordy[1]), .out_valid(ov[1]), .out_data(od[1]),
    .err_protocol(ep[1]), .err_overflow(eo[1]), .fill_level(fl[1]));

  eth_10g_st_rl_timing_adapter #(.DATA_WIDTH(DW), .IN_READY_LATENCY(1), .OUT_READY_LATENCY(3), .DEPTH(8)) u_l1m3 (
    .clk(clk), .reset(rst[2]), .in_ready(ir[2]), .in_valid(iv[2]), .in_data(id[2]),
    .out_ready(ordy[2]), .out_valid(ov[2]), .out_data(od[2]),
    .err_protocol(ep[2]), .err_overflow(eo[2]), .fill_level(fl[2]));

  int vec  = 0;
  int errs = 0;

  task automatic check_b(input string nm, input int k, input logic act, input logic exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s [inst %0d] got %b want %b", nm, k, act, exp);
    end
  endtask

  task automatic check_d(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s [inst %0d] got 0x%0h want 0x%0h", nm, k, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int k, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s [inst %0d] got %0d want %0d", nm, k, act, exp);
    end
  endtask

  // ---------------- reference model: FIFO contents as queues ----------------
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  logic [15:0]   gh  [NI];   // model grants, bit0 = last cycle
  logic [15:0]   oh  [NI];   // out_ready seen, bit0 = last cycle
  logic [15:0]   irh [NI];   // DUT in_ready seen, used by the upstream drivers
  logic [NI-1:0] mep, meo;

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qfront(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(input int k, input logic [DW-1:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  function automatic void qclear(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Compare every output of every instance each cycle, then advance the model.
  initial begin
    int sz, g;
    logic e_ir, e_ov, acc, pop, full;
    for (int k = 0; k < int'(NI); k++) begin
      gh[k] = '0; oh[k] = '0; irh[k] = '0;
    end
    mep = '0; meo = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < int'(NI); k++) begin
        sz   = qsize(k);
        g    = $countones(gh[k] & ((16'd1 << li[k]) - 16'd1));
        e_ir = !rst[k] && (sz + g < 8);
        e_ov = (sz != 0);
        if (lo[k] != 0) e_ov = e_ov && oh[k][lo[k]-1];

        check_b("in_ready", k, ir[k], e_ir);
        check_b("out_valid", k, ov[k], e_ov);
        if (e_ov) check_d("out_data", k, od[k], qfront(k));
        check_i("fill_level", k, int'(fl[k]), sz);
        check_b("err_protocol", k, ep[k], mep[k]);
        check_b("err_overflow", k, eo[k], meo[k]);

        irh[k] = {irh[k][14:0], ir[k]};
        if (rst[k]) begin
          qclear(k);
          gh[k] = '0; oh[k] = '0; mep[k] = 1'b0; meo[k] = 1'b0;
        end else begin
          full = (sz == 8);
          pop  = e_ov && (lo[k] != 0 || ordy[k]);
          acc  = (li[k] == 0) ? (iv[k] && e_ir) : iv[k];
          if (li[k] != 0 && iv[k] && !gh[k][li[k]-1]) mep[k] = 1'b1;
          if (pop) qpop(k);
          if (acc) begin
            if (!full || pop) qpush(k, id[k]);
            else              meo[k] = 1'b1;
          end
          gh[k] = {gh[k][14:0], e_ir};
          oh[k] = {oh[k][14:0], ordy[k]};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int sent, first_low;
    logic [15:0]   orec;
    logic [DW-1:0] got [$];
    logic [DW-1:0] e;

    rst = '1; iv = '0; ordy = '0;
    for (int k = 0; k < int'(NI); k++) id[k] = '0;
    repeat (3) tick();

    // Case 1: L=0, M=0, 20 beats streamed with downstream always ready.
    rst[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    check_b("c1_ready_after_reset", 0, ir[0], 1'b1);
    check_b("c1_empty_after_reset", 0, ov[0], 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(); iv[0] = 1'b1; id[0] = DW'(i);
      @(negedge clk);
      check_b("c1_ready_held", 0, ir[0], 1'b1);
      if (i == 0) check_b("c1_first_not_yet_out", 0, ov[0], 1'b0);
      else begin
        check_b("c1_valid", 0, ov[0], 1'b1);
        check_d("c1_data", 0, od[0], DW'(i - 1));
      end
    end
    tick(); iv[0] = 1'b0;
    @(negedge clk);
    check_b("c1_last_valid", 0, ov[0], 1'b1);
    check_d("c1_last_data", 0, od[0], DW'(19));
    tick();
    @(negedge clk);
    check_b("c1_drained", 0, ov[0], 1'b0);
    check_b("c1_no_perr", 0, ep[0], 1'b0);
    check_b("c1_no_oerr", 0, eo[0], 1'b0);

    // Case 3: L=1, M=3, out_ready toggles 1,0,1,0.
    orec = '0; sent = 0; got.delete();
    for (int i = 0; i < 70; i++) begin
      tick();
      rst[2]  = 1'b0;
      ordy[2] = (i % 2 == 0);
      iv[2]   = irh[2][0] && (sent < 10);
      if (iv[2]) begin id[2] = DW'(32'h200 + sent); sent++; end
      @(negedge clk);
      if (ov[2]) begin
        check_b("c3_valid_needs_ready_3_ago", 2, orec[2], 1'b1);
        got.push_back(od[2]);
      end
      orec = {orec[14:0], ordy[2]};
    end
    tick(); iv[2] = 1'b0; rst[2] = 1'b1;
    check_i("c3_beats_out", 2, got.size(), 10);
    for (int j = 0; j < got.size() && j < 10; j++)
      check_d("c3_order", 2, got[j], DW'(32'h200 + j));

    // Case 2: L=2, M=0, downstream stalled, upstream uses every grant.
    sent = 0; first_low = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      rst[1] = 1'b0;
      iv[1]  = irh[1][1];
      if (iv[1]) begin id[1] = DW'(32'h100 + sent); sent++; end
      @(negedge clk);
      if (!ir[1] && first_low < 0) first_low = i;
    end
    check_i("c2_ready_low_cycle", 1, first_low, 8);
    check_i("c2_beats_accepted", 1, sent, 8);
    check_i("c2_fill_full", 1, int'(fl[1]), 8);
    check_b("c2_ready_low", 1, ir[1], 1'b0);
    check_b("c2_no_oerr", 1, eo[1], 1'b0);
    check_b("c2_no_perr", 1, ep[1], 1'b0);
    tick(); iv[1] = 1'b0; ordy[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check_b("c2_drain_valid", 1, ov[1], 1'b1);
      check_d("c2_drain_data", 1, od[1], DW'(32'h100 + j));
      tick();
    end
    @(negedge clk);
    check_b("c2_drain_done", 1, ov[1], 1'b0);

    // Case 4a: ungranted beat right after reset sets err_protocol.
    tick(); rst[1] = 1'b1; ordy[1] = 1'b0;
    tick();
    tick(); rst[1] = 1'b0; iv[1] = 1'b1; id[1] = DW'(32'hBAD0);
    @(negedge clk);
    check_b("c4_perr_not_yet", 1, ep[1], 1'b0);
    tick(); iv[1] = 1'b0;
    @(negedge clk);
    check_b("c4_perr_set", 1, ep[1], 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check_b("c4_perr_sticky", 1, ep[1], 1'b1);

    // Case 4b: fill to full, then one more ungranted beat is dropped.
    sent = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      iv[1] = irh[1][1];
      if (iv[1]) begin id[1] = DW'(32'h400 + sent); sent++; end
    end
    check_i("c4_fill_beats", 1, sent, 7);
    tick(); iv[1] = 1'b1; id[1] = DW'(32'hDEAD);
    @(negedge clk);
    check_b("c4_no_grant", 1, ir[1], 1'b0);
    check_i("c4_full", 1, int'(fl[1]), 8);
    tick(); iv[1] = 1'b0;
    @(negedge clk);
    check_b("c4_oerr_set", 1, eo[1], 1'b1);
    check_i("c4_still_full", 1, int'(fl[1]), 8);
    tick(); ordy[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      e = (j == 0) ? DW'(32'hBAD0) : DW'(32'h400 + j - 1);
      check_b("c4_drain_valid", 1, ov[1], 1'b1);
      check_d("c4_drain_data", 1, od[1], e);
      tick();
    end
    @(negedge clk);
    check_b("c4_dropped_absent", 1, ov[1], 1'b0);

    // Case 5: reset with five beats queued and both errors set.
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ordy[1] = 1'b0;
      iv[1]   = irh[1][1] && (sent < 5);
      if (iv[1]) begin id[1] = DW'(32'h500 + sent); sent++; end
    end
    tick(); iv[1] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_i("c5_fill_five", 1, int'(fl[1]), 5);
    check_b("c5_perr_before", 1, ep[1], 1'b1);
    check_b("c5_oerr_before", 1, eo[1], 1'b1);
    tick(); rst[1] = 1'b1; iv[1] = 1'b1; id[1] = DW'(32'hEEE); ordy[1] = 1'b1;
    @(negedge clk);
    check_b("c5_ready_gated", 1, ir[1], 1'b0);
    tick();
    @(negedge clk);
    check_i("c5_fill_cleared", 1, int'(fl[1]), 0);
    check_b("c5_valid_cleared", 1, ov[1], 1'b0);
    check_b("c5_ready_in_reset", 1, ir[1], 1'b0);
    tick(); rst[1] = 1'b0; iv[1] = 1'b0;
    @(negedge clk);
    check_b("c5_ready_after", 1, ir[1], 1'b1);
    check_b("c5_perr_cleared", 1, ep[1], 1'b0);
    check_b("c5_oerr_cleared", 1, eo[1], 1'b0);
    check_i("c5_fill_after", 1, int'(fl[1]), 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
